// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - direction encoding shared by the snake input stage
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_RIGHT = 2'b01;
  localparam dir_t DIR_DOWN  = 2'b10;
  localparam dir_t DIR_LEFT  = 2'b11;
  localparam dir_t DIR_RESET = DIR_RIGHT;

  function automatic dir_t opposite(input dir_t d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer, debouncer and press pulse for one button
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // Level flips on the increment that would reach DEBOUNCE_CYCLES; only rising flips pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/snake_dir_ctrl.sv
// rtl/snake_dir_ctrl.sv - button debounce, two-deep turn queue and game tick for the snake FSM
// Optional SNAKE_DIR_STATS_EN adds DropCnt, a saturating count of rejected presses.
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_CYCLES     = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       BtnU,
  input  logic       BtnR,
  input  logic       BtnD,
  input  logic       BtnL,
  input  logic       Enable,
  output logic       Tick,
  output logic [1:0] Dir,
  output logic [1:0] PendingCnt
`ifdef SNAKE_DIR_STATS_EN
  ,
  output logic [7:0] DropCnt
`endif
);

  localparam int TW = $clog2(TICK_CYCLES);

  logic [3:0]    w_btn;
  logic [3:0]    w_press;
  logic          w_cand_vld;
  dir_t          w_cand;
  logic          w_fire;
  logic          w_pop;
  logic          w_push;
  logic [1:0]    w_cnt_p;
  logic [1:0]    w_cnt_nxt;
  dir_t          w_dir_nxt;
  dir_t          w_e0;
  dir_t          w_ref;
  dir_t          w_q0_nxt;
  dir_t          w_q1_nxt;

  logic [TW-1:0] r_tcnt;
  logic          r_tick;
  dir_t          r_dir;
  dir_t          r_q0;
  dir_t          r_q1;
  logic [1:0]    r_cnt;

  // Bit index equals the direction code, so the debounce outputs line up with dir_t.
  assign w_btn = {BtnL, BtnD, BtnR, BtnU};

  for (genvar gi = 0; gi < 4; gi++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .i_clk  (Clk),
      .i_rst  (Reset),
      .i_btn  (w_btn[gi]),
      .o_press(w_press[gi])
    );
  end

  always_comb begin
    w_cand_vld = Enable && (w_press != 4'b0000);
    w_cand     = DIR_UP;
    if (w_press[0])      w_cand = DIR_UP;
    else if (w_press[1]) w_cand = DIR_RIGHT;
    else if (w_press[2]) w_cand = DIR_DOWN;
    else                 w_cand = DIR_LEFT;
  end

  assign w_fire = Enable && (r_tcnt == TW'(TICK_CYCLES - 1));

  // Pop is resolved first; the press is judged against the post-pop tail (or Dir).
  always_comb begin
    w_pop     = w_fire && (r_cnt != 2'd0);
    w_dir_nxt = w_pop ? r_q0 : r_dir;
    w_e0      = w_pop ? r_q1 : r_q0;
    w_cnt_p   = r_cnt - {1'b0, w_pop};
    if (w_cnt_p == 2'd0)      w_ref = w_dir_nxt;
    else if (w_cnt_p == 2'd1) w_ref = w_e0;
    else                      w_ref = r_q1;
    w_push    = w_cand_vld && (w_cnt_p != 2'd2) &&
                (w_cand != w_ref) && (w_cand != opposite(w_ref));
    w_q0_nxt  = w_e0;
    w_q1_nxt  = r_q1;
    if (w_push) begin
      if (w_cnt_p == 2'd0) w_q0_nxt = w_cand;
      else                 w_q1_nxt = w_cand;
    end
    w_cnt_nxt = w_cnt_p + {1'b0, w_push};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_tcnt <= '0;
      r_tick <= 1'b0;
      r_dir  <= DIR_RESET;
      r_q0   <= DIR_RESET;
      r_q1   <= DIR_RESET;
      r_cnt  <= 2'd0;
    end else if (!Enable) begin
      r_tcnt <= '0;
      r_tick <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      r_tcnt <= w_fire ? '0 : r_tcnt + 1'b1;
      r_tick <= w_fire;
      r_dir  <= w_dir_nxt;
      r_q0   <= w_q0_nxt;
      r_q1   <= w_q1_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign Tick       = r_tick;
  assign Dir        = r_dir;
  assign PendingCnt = r_cnt;

`ifdef SNAKE_DIR_STATS_EN
  logic [7:0] r_drop;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_drop <= 8'd0;
    end else if (w_cand_vld && !w_push && (r_drop != 8'hFF)) begin
      r_drop <= r_drop + 1'b1;
    end
  end

  assign DropCnt = r_drop;
`else
`endif

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb/tb_snake_dir_ctrl.sv - directed self-checking bench for snake_dir_ctrl
module tb_snake_dir_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       BtnU = 1'b0;
  logic       BtnR = 1'b0;
  logic       BtnD = 1'b0;
  logic       BtnL = 1'b0;
  logic       Enable = 1'b0;
  logic       Tick;
  logic [1:0] Dir;
  logic [1:0] PendingCnt;
`ifdef SNAKE_DIR_STATS_EN
  logic [7:0] DropCnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  snake_dir_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TICK_CYCLES    (16)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .BtnU      (BtnU),
    .BtnR      (BtnR),
    .BtnD      (BtnD),
    .BtnL      (BtnL),
    .Enable    (Enable),
    .Tick      (Tick),
    .Dir       (Dir),
    .PendingCnt(PendingCnt)
`ifdef SNAKE_DIR_STATS_EN
    ,
    .DropCnt   (DropCnt)
`endif
  );

  task automatic tk(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_drop(input string tag, input logic [7:0] exp);
`ifdef SNAKE_DIR_STATS_EN
    chk(tag, DropCnt, exp);
`else
    if (exp === 8'hxx) $display("unused %s", tag);
`endif
  endtask

  initial begin
    tk(1);
    chk("rst_dir", {6'd0, Dir}, 8'd1);
    chk("rst_tick", {7'd0, Tick}, 8'd0);
    chk("rst_pc", {6'd0, PendingCnt}, 8'd0);
    chk_drop("rst_drop", 8'd0);
    tk(2);
    Reset = 1'b0;
    tk(2);

    // Tick cadence; edge count e is relative to Enable rising
    Enable = 1'b1;
    tk(15);
    chk("tick_e15", {7'd0, Tick}, 8'd0);
    tk(1);
    chk("tick_e16", {7'd0, Tick}, 8'd1);
    chk("dir_e16", {6'd0, Dir}, 8'd1);
    tk(1);
    chk("tick_e17", {7'd0, Tick}, 8'd0);
    tk(15);
    chk("tick_e32", {7'd0, Tick}, 8'd1);
    tk(16);
    chk("tick_e48", {7'd0, Tick}, 8'd1);
    chk("dir_e48", {6'd0, Dir}, 8'd1);

    // Two-cycle glitch on U
    BtnU = 1'b1;
    tk(2);
    BtnU = 1'b0;
    tk(10);
    chk("glitch_pc", {6'd0, PendingCnt}, 8'd0);

    // Reversal from RIGHT
    BtnL = 1'b1;
    tk(10);
    BtnL = 1'b0;
    chk("rev_pc", {6'd0, PendingCnt}, 8'd0);
    chk_drop("rev_drop", 8'd1);
    tk(10);
    chk("rev_tick", {7'd0, Tick}, 8'd1);
    chk("rev_dir", {6'd0, Dir}, 8'd1);

    // D held 12 cycles -> exactly one turn
    BtnD = 1'b1;
    tk(12);
    BtnD = 1'b0;
    chk("d_pc", {6'd0, PendingCnt}, 8'd1);
    tk(3);
    chk("d_pc_once", {6'd0, PendingCnt}, 8'd1);
    tk(1);
    chk("d_tick", {7'd0, Tick}, 8'd1);
    chk("d_dir", {6'd0, Dir}, 8'd2);
    chk("d_pc_pop", {6'd0, PendingCnt}, 8'd0);

    // Back to RIGHT
    BtnR = 1'b1;
    tk(8);
    BtnR = 1'b0;
    chk("r_pc", {6'd0, PendingCnt}, 8'd1);
    tk(8);
    chk("r_dir", {6'd0, Dir}, 8'd1);
    chk("r_pc_pop", {6'd0, PendingCnt}, 8'd0);

    // U then L queued, D dropped on full queue
    BtnU = 1'b1;
    tk(1);
    BtnL = 1'b1;
    tk(1);
    BtnD = 1'b1;
    tk(7);
    BtnU = 1'b0;
    BtnL = 1'b0;
    BtnD = 1'b0;
    chk("full_pc", {6'd0, PendingCnt}, 8'd2);
    chk_drop("full_drop", 8'd2);
    tk(7);
    chk("q_tick1", {7'd0, Tick}, 8'd1);
    chk("q_dir1", {6'd0, Dir}, 8'd0);
    chk("q_pc1", {6'd0, PendingCnt}, 8'd1);
    tk(16);
    chk("q_dir2", {6'd0, Dir}, 8'd3);
    chk("q_pc2", {6'd0, PendingCnt}, 8'd0);

    // Full {U,R}, L lands on the Tick: pop U, L opposes new tail R
    BtnU = 1'b1;
    tk(1);
    BtnR = 1'b1;
    tk(8);
    chk("ur_pc", {6'd0, PendingCnt}, 8'd2);
    BtnU = 1'b0;
    BtnR = 1'b0;
    BtnL = 1'b1;
    tk(7);
    BtnL = 1'b0;
    chk("tl_tick", {7'd0, Tick}, 8'd1);
    chk("tl_dir", {6'd0, Dir}, 8'd0);
    chk("tl_pc", {6'd0, PendingCnt}, 8'd1);
    chk_drop("tl_drop", 8'd3);
    tk(16);
    chk("tl_dir2", {6'd0, Dir}, 8'd1);
    chk("tl_pc2", {6'd0, PendingCnt}, 8'd0);

    // Full {U,R}, D lands on the Tick: pop and push together
    BtnU = 1'b1;
    tk(1);
    BtnR = 1'b1;
    tk(8);
    chk("ur2_pc", {6'd0, PendingCnt}, 8'd2);
    BtnU = 1'b0;
    BtnR = 1'b0;
    BtnD = 1'b1;
    tk(7);
    BtnD = 1'b0;
    chk("td_tick", {7'd0, Tick}, 8'd1);
    chk("td_dir", {6'd0, Dir}, 8'd0);
    chk("td_pc", {6'd0, PendingCnt}, 8'd2);
    chk_drop("td_drop", 8'd3);
    Enable = 1'b0;
    tk(1);
    chk("dis_pc", {6'd0, PendingCnt}, 8'd0);
    chk("dis_tick", {7'd0, Tick}, 8'd0);
    chk("dis_dir", {6'd0, Dir}, 8'd0);

    // Presses while disabled are ignored and not counted
    BtnL = 1'b1;
    tk(8);
    BtnL = 1'b0;
    tk(20);
    chk("dis_press_pc", {6'd0, PendingCnt}, 8'd0);
    chk("dis_press_dir", {6'd0, Dir}, 8'd0);
    chk_drop("dis_press_drop", 8'd3);

    // R and L together: R wins, L discarded silently; then D
    Enable = 1'b1;
    BtnR = 1'b1;
    BtnL = 1'b1;
    tk(1);
    BtnD = 1'b1;
    tk(7);
    BtnR = 1'b0;
    BtnL = 1'b0;
    BtnD = 1'b0;
    chk("prio_pc", {6'd0, PendingCnt}, 8'd2);
    tk(8);
    chk("prio_tick", {7'd0, Tick}, 8'd1);
    chk("prio_dir", {6'd0, Dir}, 8'd1);
    chk("prio_pc1", {6'd0, PendingCnt}, 8'd1);
    chk_drop("prio_drop", 8'd3);
    BtnL = 1'b1;
    tk(8);
    BtnL = 1'b0;
    chk("fill_pc", {6'd0, PendingCnt}, 8'd2);

    // Asynchronous reset mid-run with a full queue
    #3;
    Reset = 1'b1;
    #1;
    chk("arst_dir", {6'd0, Dir}, 8'd1);
    chk("arst_pc", {6'd0, PendingCnt}, 8'd0);
    chk("arst_tick", {7'd0, Tick}, 8'd0);
    chk_drop("arst_drop", 8'd0);

    // U held through reset -> one press after release
    Enable = 1'b0;
    BtnU = 1'b1;
    tk(2);
    Reset = 1'b0;
    Enable = 1'b1;
    tk(12);
    chk("held_pc", {6'd0, PendingCnt}, 8'd1);
    tk(4);
    chk("held_tick", {7'd0, Tick}, 8'd1);
    chk("held_dir", {6'd0, Dir}, 8'd0);
    chk("held_pc_pop", {6'd0, PendingCnt}, 8'd0);
    BtnU = 1'b0;
    tk(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
